// File: rtl/galaga_pkg.sv
// Shared types and default sizing for the missile shot arbiter.
package galaga_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StPlay,
        StDrain
    } state_e;

    localparam int unsigned DefNslot       = 4;
    localparam int unsigned DefCooldown    = 8;
    localparam int unsigned DefMaxInflight = 2;

    // 0 = player 1, 1 = player 2
    typedef logic player_t;
    localparam player_t Player1 = 1'b0;
    localparam player_t Player2 = 1'b1;

endpackage

// File: rtl/shot_player_ctrl.sv
// Per-player fire bookkeeping: key sample, pending flag, cooldown and inflight count.
// SHOT_AUTOFIRE_EN makes a held key re-arm the pending flag once the cooldown is over.
module shot_player_ctrl
    import galaga_pkg::*;
#(
    parameter int unsigned  COOLDOWN     = DefCooldown,
    parameter int unsigned  MAX_INFLIGHT = DefMaxInflight,
    localparam int unsigned CntW         = $clog2(MAX_INFLIGHT + 1),
    localparam int unsigned CdW          = $clog2(COOLDOWN + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            frame_tick_i,
    input  logic            key_i,
    input  logic            play_i,
    input  logic            grant_i,
    input  logic [CntW-1:0] release_cnt_i,
    output logic            pending_o,
    output logic            ready_o
);

    logic            key_q, key_d;
    logic            pending_q, pending_d;
    logic [CdW-1:0]  cd_q, cd_d;
    logic [CntW-1:0] inflight_q, inflight_d;
    logic            set_pending;
    logic [CntW:0]   sum;

`ifdef SHOT_AUTOFIRE_EN
    assign set_pending = frame_tick_i & key_i & (cd_q == '0);
`else
    assign set_pending = frame_tick_i & key_i & ~key_q;
`endif

    always_comb begin
        key_d      = frame_tick_i ? key_i : key_q;
        pending_d  = pending_q;
        cd_d       = cd_q;
        inflight_d = inflight_q;
        sum        = {1'b0, inflight_q} + {{CntW{1'b0}}, grant_i};

        if (!play_i || grant_i) begin
            pending_d = 1'b0;
        end else if (set_pending) begin
            pending_d = 1'b1;
        end

        // A grant reloads the cooldown even when a tick lands on the same edge.
        if (grant_i) begin
            cd_d = CdW'(COOLDOWN);
        end else if (frame_tick_i && cd_q != '0) begin
            cd_d = cd_q - CdW'(1);
        end

        if (sum > {1'b0, release_cnt_i}) begin
            inflight_d = CntW'(sum - {1'b0, release_cnt_i});
        end else begin
            inflight_d = '0;
        end
        if (inflight_d > CntW'(MAX_INFLIGHT)) begin
            inflight_d = CntW'(MAX_INFLIGHT);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            key_q      <= 1'b0;
            pending_q  <= 1'b0;
            cd_q       <= '0;
            inflight_q <= '0;
        end else begin
            key_q      <= key_d;
            pending_q  <= pending_d;
            cd_q       <= cd_d;
            inflight_q <= inflight_d;
        end
    end

    assign pending_o = pending_q;
    assign ready_o   = (cd_q == '0) && (inflight_q < CntW'(MAX_INFLIGHT));

endmodule

// File: rtl/shot_arbiter.sv
// Two-player shot arbiter: game FSM, shared missile slot table and round-robin offer logic.
// Optional auto-fire is selected with SHOT_AUTOFIRE_EN (see shot_player_ctrl).
module shot_arbiter
    import galaga_pkg::*;
#(
    parameter int unsigned  NSLOT        = DefNslot,
    parameter int unsigned  COOLDOWN     = DefCooldown,
    parameter int unsigned  MAX_INFLIGHT = DefMaxInflight,
    localparam int unsigned SlotW        = $clog2(NSLOT)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             frame_tick_i,
    input  logic             shoot_i,
    input  logic             shoot2_i,
    input  logic             start_i,
    input  logic             restart_i,
    input  logic [NSLOT-1:0] slot_release_i,
    input  logic             fire_ready_i,
    output logic             fire_valid_o,
    output logic             fire_player_o,
    output logic [SlotW-1:0] fire_slot_o,
    output logic             game_active_o,
    output logic [NSLOT-1:0] slot_busy_o
);

    localparam int unsigned CntW = $clog2(MAX_INFLIGHT + 1);

    state_e           state_q, state_d;
    logic [NSLOT-1:0] slot_busy_q, slot_busy_d;
    logic [NSLOT-1:0] slot_owner_q, slot_owner_d;
    logic             fire_valid_q, fire_valid_d;
    player_t          fire_player_q, fire_player_d;
    logic [SlotW-1:0] fire_slot_q, fire_slot_d;
    player_t          last_q, last_d;

    logic             play, accept, offer, any_free;
    logic [1:0]       pend, rdy, elig, grant;
    logic [NSLOT-1:0] rel_eff;
    logic [SlotW-1:0] free_slot;
    player_t          pick;
    logic [CntW-1:0]  rel_cnt1, rel_cnt2;

    assign play     = (state_q == StPlay);
    assign accept   = fire_valid_q & fire_ready_i;
    assign any_free = ~&slot_busy_q;
    assign rel_eff  = slot_release_i & slot_busy_q;
    assign elig     = {2{play & any_free}} & pend & rdy;
    assign offer    = ~fire_valid_q & (|elig) & ~restart_i;
    assign grant[0] = accept & (fire_player_q == Player1);
    assign grant[1] = accept & (fire_player_q == Player2);

    always_comb begin
        free_slot = '0;
        rel_cnt1  = '0;
        rel_cnt2  = '0;
        for (int i = NSLOT - 1; i >= 0; i--) begin
            if (!slot_busy_q[i]) free_slot = SlotW'(i);
        end
        for (int i = 0; i < NSLOT; i++) begin
            if (rel_eff[i] && slot_owner_q[i] == Player1) rel_cnt1 = rel_cnt1 + CntW'(1);
            if (rel_eff[i] && slot_owner_q[i] == Player2) rel_cnt2 = rel_cnt2 + CntW'(1);
        end
        if (&elig) begin
            pick = ~last_q;
        end else begin
            pick = elig[1] ? Player2 : Player1;
        end
    end

    always_comb begin
        state_d       = state_q;
        slot_busy_d   = slot_busy_q & ~rel_eff;
        slot_owner_d  = slot_owner_q;
        fire_valid_d  = fire_valid_q;
        fire_player_d = fire_player_q;
        fire_slot_d   = fire_slot_q;
        last_d        = last_q;

        if (accept) begin
            fire_valid_d              = 1'b0;
            slot_busy_d[fire_slot_q]  = 1'b1;
            slot_owner_d[fire_slot_q] = fire_player_q;
            last_d                    = fire_player_q;
        end else if (offer) begin
            fire_valid_d  = 1'b1;
            fire_player_d = pick;
            fire_slot_d   = free_slot;
        end

        unique case (state_q)
            StIdle:  if (start_i) state_d = StPlay;
            // Never leave PLAY with an offer still waiting on the engine.
            StPlay:  if (restart_i && !(fire_valid_q && !fire_ready_i)) state_d = StDrain;
            StDrain: if (slot_busy_q == '0) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= StIdle;
            slot_busy_q   <= '0;
            slot_owner_q  <= '0;
            fire_valid_q  <= 1'b0;
            fire_player_q <= Player1;
            fire_slot_q   <= '0;
            last_q        <= Player2;
        end else begin
            state_q       <= state_d;
            slot_busy_q   <= slot_busy_d;
            slot_owner_q  <= slot_owner_d;
            fire_valid_q  <= fire_valid_d;
            fire_player_q <= fire_player_d;
            fire_slot_q   <= fire_slot_d;
            last_q        <= last_d;
        end
    end

    shot_player_ctrl #(
        .COOLDOWN     (COOLDOWN),
        .MAX_INFLIGHT (MAX_INFLIGHT)
    ) u_player1 (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .frame_tick_i  (frame_tick_i),
        .key_i         (shoot_i),
        .play_i        (play),
        .grant_i       (grant[0]),
        .release_cnt_i (rel_cnt1),
        .pending_o     (pend[0]),
        .ready_o       (rdy[0])
    );

    shot_player_ctrl #(
        .COOLDOWN     (COOLDOWN),
        .MAX_INFLIGHT (MAX_INFLIGHT)
    ) u_player2 (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .frame_tick_i  (frame_tick_i),
        .key_i         (shoot2_i),
        .play_i        (play),
        .grant_i       (grant[1]),
        .release_cnt_i (rel_cnt2),
        .pending_o     (pend[1]),
        .ready_o       (rdy[1])
    );

    assign fire_valid_o  = fire_valid_q;
    assign fire_player_o = fire_player_q;
    assign fire_slot_o   = fire_slot_q;
    assign game_active_o = play;
    assign slot_busy_o   = slot_busy_q;

endmodule
